// File: rtl/phy_pkg.sv
// phy_pkg: constants and types shared by the phy lane blocks.
//   COMMA       idle/alignment byte; never carried as data
//   SYNC_COUNT  consecutive aligned commas required to declare the lane active
//   WORD_W      parallel word width
//   BYTE_W      serial byte width
//   rx_state_e  receive aligner state encoding
package phy_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] COMMA      = 8'hBC;
  localparam logic [2:0]        SYNC_COUNT = 3'd4;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SYNC   = 2'd1,
    ACTIVE = 2'd2
  } rx_state_e;

endpackage

// File: rtl/phy_rx_alineador.sv
// phy_rx_alineador: bit-level byte alignment for one serial lane.
// Slides an 8-bit window over the serial stream until the comma appears,
// fixes the byte boundary there, and then requires SYNC_COUNT consecutive
// aligned commas before the lane is declared active.
// Ports:
//   clk_32f     serial bit clock
//   reset       synchronous, active-high
//   serial_i    serial lane, MSB first
//   rx_byte_o   byte completed on this edge (valid with byte_stb_o)
//   byte_stb_o  high during the cycle whose edge completes an aligned byte
//   is_comma_o  rx_byte_o equals COMMA
//   active_o    lane aligned and synchronized (registered)
//   state_o     current aligner state (debug)
module phy_rx_alineador
  import phy_pkg::*;
(
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              serial_i,
  output logic [BYTE_W-1:0] rx_byte_o,
  output logic              byte_stb_o,
  output logic              is_comma_o,
  output logic              active_o,
  output rx_state_e         state_o
);

  rx_state_e         state_q, state_d;
  logic [BYTE_W-1:0] sr_q;
  logic [BYTE_W-1:0] nsr;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [2:0]        comma_cnt_q, comma_cnt_d;
  logic              byte_done;

  // nsr is the window as it will look after this edge.
  assign nsr        = {sr_q[BYTE_W-2:0], serial_i};
  // A byte completes when bit_cnt wraps 7 -> 0; the boundary edge set it to 0.
  assign byte_done  = (state_q != SEARCH) && (bit_cnt_q == 3'd7);
  assign rx_byte_o  = nsr;
  assign byte_stb_o = byte_done;
  assign is_comma_o = (nsr == COMMA);
  assign active_o   = (state_q == ACTIVE);
  assign state_o    = state_q;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    case (state_q)
      SEARCH: begin
        if (nsr == COMMA) begin
          bit_cnt_d   = 3'd0;
          comma_cnt_d = 3'd1;
          state_d     = SYNC;
        end
      end
      SYNC: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (byte_done) begin
          if (nsr == COMMA) begin
            comma_cnt_d = comma_cnt_q + 3'd1;
            if (comma_cnt_q + 3'd1 == SYNC_COUNT) begin
              state_d = ACTIVE;
            end
          end else begin
            // Misaligned or corrupted: resume sliding search next edge.
            comma_cnt_d = 3'd0;
            state_d     = SEARCH;
          end
        end
      end
      ACTIVE: begin
        // Left only through reset.
        bit_cnt_d = bit_cnt_q + 3'd1;
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= SEARCH;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      sr_q        <= nsr;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
    end
  end

endmodule

// File: rtl/phy_rx_deserializador.sv
// phy_rx_deserializador: receive-side deserializer for one phy_tx lane.
// Aligns on the idle comma, then packs four non-comma bytes (first byte in
// [31:24]) into a word presented with a one-cycle valid pulse. A comma in
// the middle of a word discards the partial word and pulses err_partial.
// Ports:
//   clk_32f      serial bit clock
//   reset        synchronous, active-high
//   serial_in    serial lane from phy_tx, MSB first
//   data_out     last completed word, held between pulses
//   valid_out    one-cycle pulse, data_out newly updated
//   active       lane aligned and synchronized
//   err_partial  one-cycle pulse, partial word discarded by a comma
module phy_rx_deserializador
  import phy_pkg::*;
(
  input  logic              clk_32f,
  input  logic              reset,
  input  logic              serial_in,
  output logic [WORD_W-1:0] data_out,
  output logic              valid_out,
  output logic              active,
  output logic              err_partial
);

  logic [BYTE_W-1:0]        rx_byte;
  logic                     byte_stb;
  logic                     is_comma;
  rx_state_e                rx_state;

  logic [1:0]               byte_idx_q, byte_idx_d;
  logic [WORD_W-BYTE_W-1:0] asm_q, asm_d;
  logic [WORD_W-1:0]        data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     err_q, err_d;

  phy_rx_alineador u_alineador (
    .clk_32f    (clk_32f),
    .reset      (reset),
    .serial_i   (serial_in),
    .rx_byte_o  (rx_byte),
    .byte_stb_o (byte_stb),
    .is_comma_o (is_comma),
    .active_o   (active),
    .state_o    (rx_state)
  );

  always_comb begin
    byte_idx_d = byte_idx_q;
    asm_d      = asm_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    if ((rx_state == ACTIVE) && byte_stb) begin
      if (!is_comma) begin
        if (byte_idx_q == 2'd3) begin
          data_d     = {asm_q, rx_byte};
          valid_d    = 1'b1;
          byte_idx_d = 2'd0;
        end else begin
          asm_d      = {asm_q[WORD_W-2*BYTE_W-1:0], rx_byte};
          byte_idx_d = byte_idx_q + 2'd1;
        end
      end else if (byte_idx_q != 2'd0) begin
        // Comma mid-word: drop what was gathered, keep data_out.
        byte_idx_d = 2'd0;
        err_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      byte_idx_q <= '0;
      asm_q      <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      byte_idx_q <= byte_idx_d;
      asm_q      <= asm_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign data_out    = data_q;
  assign valid_out   = valid_q;
  assign err_partial = err_q;

endmodule
